// File: rtl/mdu_div_pkg.sv
// Shared definitions for the divide unit: operation encodings, the zero word
// and small decode helpers for the operation field.
package mdu_div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } mdu_op_e;

    localparam int unsigned MAX_XLEN = 64;
    localparam logic [MAX_XLEN-1:0] ZERO_WORD = '0;

    // Signed operations take absolute values and fix the sign afterwards.
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Remainder operations return the remainder instead of the quotient.
    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/mdu_div_if.sv
// Request/response bundle between the pipeline and the divide unit.
interface mdu_div_if #(
    parameter int unsigned XLEN = 32
);
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] dividend_i;
    logic [XLEN-1:0] divisor_i;
    logic            flush_i;
    logic            hold_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, op_i, dividend_i, divisor_i, flush_i,
        input  hold_o, busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, op_i, dividend_i, divisor_i, flush_i,
        output hold_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/mdu_div.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
// Divide-by-zero and signed overflow are resolved at accept time and skip
// the iteration. The result register holds its value between operations.
module mdu_div
    import mdu_div_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic     clk,
    input  logic     rst,
    mdu_div_if.slave bus
);

    localparam int unsigned     CW         = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0]   LAST_COUNT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] ZERO       = ZERO_WORD[XLEN-1:0];
    localparam logic [XLEN-1:0] ONES       = ~ZERO;
    localparam logic [XLEN-1:0] MIN_INT    = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_e;

    state_e          state_reg,  state_next;
    logic [1:0]      op_reg,     op_next;
    logic [XLEN-1:0] quot_reg,   quot_next;
    logic [XLEN-1:0] rem_reg,    rem_next;
    logic [XLEN-1:0] dvsr_reg,   dvsr_next;
    logic [CW-1:0]   count_reg,  count_next;
    logic            neg_q_reg,  neg_q_next;
    logic            neg_r_reg,  neg_r_next;
    logic [XLEN-1:0] result_reg, result_next;

    // Operand conditioning for the accept cycle
    logic            in_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            is_ovf;

    // One restoring step plus the sign-corrected final result
    logic [XLEN:0]   partial;
    logic [XLEN:0]   diff;
    logic            step_bit;
    logic [XLEN-1:0] step_quot;
    logic [XLEN-1:0] step_rem;
    logic [XLEN-1:0] final_q;
    logic [XLEN-1:0] final_r;

    // Absolute values and sign flags of the incoming operands
    always_comb begin
        in_signed = op_is_signed(bus.op_i);
        a_neg     = in_signed & bus.dividend_i[XLEN-1];
        b_neg     = in_signed & bus.divisor_i[XLEN-1];
        abs_a     = a_neg ? (ZERO - bus.dividend_i) : bus.dividend_i;
        abs_b     = b_neg ? (ZERO - bus.divisor_i)  : bus.divisor_i;
        is_ovf    = in_signed && (bus.dividend_i == MIN_INT) && (bus.divisor_i == ONES);
    end

    // Shift the next dividend bit into the partial remainder and trial-subtract
    always_comb begin
        partial   = {rem_reg, quot_reg[XLEN-1]};
        diff      = partial - {1'b0, dvsr_reg};
        step_bit  = ~diff[XLEN];
        step_rem  = step_bit ? diff[XLEN-1:0] : partial[XLEN-1:0];
        step_quot = {quot_reg[XLEN-2:0], step_bit};
        final_q   = neg_q_reg ? (ZERO - step_quot) : step_quot;
        final_r   = neg_r_reg ? (ZERO - step_rem)  : step_rem;
    end

    // Next-state, datapath updates and outputs
    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        quot_next   = quot_reg;
        rem_next    = rem_reg;
        dvsr_next   = dvsr_reg;
        count_next  = count_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        result_next = result_reg;

        bus.busy_o   = (state_reg == ST_CALC);
        bus.done_o   = (state_reg == ST_DONE);
        bus.result_o = result_reg;
        bus.hold_o   = ~rst & (((state_reg == ST_IDLE) & bus.start_i & ~bus.flush_i)
                               | (state_reg == ST_CALC));

        unique case (state_reg)
            ST_IDLE: begin
                if (bus.start_i) begin
                    op_next    = bus.op_i;
                    quot_next  = abs_a;
                    rem_next   = ZERO;
                    dvsr_next  = abs_b;
                    count_next = '0;
                    neg_q_next = a_neg ^ b_neg;
                    neg_r_next = a_neg;
                    if (bus.divisor_i == ZERO) begin
                        // Quotient all ones, remainder is the raw dividend
                        result_next = op_is_rem(bus.op_i) ? bus.dividend_i : ONES;
                        state_next  = ST_DONE;
                    end else if (is_ovf) begin
                        result_next = op_is_rem(bus.op_i) ? ZERO : MIN_INT;
                        state_next  = ST_DONE;
                    end else begin
                        state_next  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                quot_next  = step_quot;
                rem_next   = step_rem;
                count_next = count_reg + CW'(1);
                if (count_reg == LAST_COUNT) begin
                    result_next = op_is_rem(op_reg) ? final_r : final_q;
                    state_next  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Flush abandons the operation and leaves the previous result intact
        if (bus.flush_i) begin
            state_next  = ST_IDLE;
            result_next = result_reg;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            op_reg     <= '0;
            quot_reg   <= ZERO;
            rem_reg    <= ZERO;
            dvsr_reg   <= ZERO;
            count_reg  <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= ZERO;
        end else begin
            state_reg  <= state_next;
            op_reg     <= op_next;
            quot_reg   <= quot_next;
            rem_reg    <= rem_next;
            dvsr_reg   <= dvsr_next;
            count_reg  <= count_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            result_reg <= result_next;
        end
    end

endmodule

// File: tb/tb_mdu_div.sv
// Directed bench for the divide unit: expected values are hand-computed.
module tb_mdu_div;
    import mdu_div_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    mdu_div_if #(.XLEN(32)) bus ();

    mdu_div #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE (called 1 time unit after a rising edge)
    // and follow it to the done pulse.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cycles;
        bus.start_i    = 1'b1;
        bus.op_i       = op;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        #1;
        check({tag, "/hold_accept"}, 32'(bus.hold_o), 32'd1);
        @(posedge clk); #1;
        bus.start_i    = 1'b0;
        bus.dividend_i = 32'hDEAD_BEEF;
        bus.divisor_i  = 32'h0000_0000;
        cycles = 1;
        while (bus.done_o !== 1'b1 && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        check({tag, "/latency"}, 32'(cycles), 32'(lat));
        check({tag, "/result"}, bus.result_o, exp);
        check({tag, "/hold_done"}, 32'(bus.hold_o), 32'd0);
        check({tag, "/busy_done"}, 32'(bus.busy_o), 32'd0);
        @(posedge clk); #1;
        check({tag, "/done_pulse"}, 32'(bus.done_o), 32'd0);
        check({tag, "/result_held"}, bus.result_o, exp);
        $display("[TB] %s op=%0d a=%h b=%h result=%h cycles=%0d", tag, op, a, b, bus.result_o, cycles);
    endtask

    initial begin
        int cycles;
        int dones;
        tests_run    = 0;
        tests_failed = 0;

        // Reset with a pending start: nothing may be requested or held
        rst            = 1'b1;
        bus.start_i    = 1'b1;
        bus.op_i       = OP_DIVU;
        bus.dividend_i = 32'd100;
        bus.divisor_i  = 32'd7;
        bus.flush_i    = 1'b0;
        #1;
        check("reset/hold_comb", 32'(bus.hold_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset/busy", 32'(bus.busy_o), 32'd0);
        check("reset/done", 32'(bus.done_o), 32'd0);
        check("reset/result", bus.result_o, 32'd0);
        check("reset/hold", 32'(bus.hold_o), 32'd0);
        rst         = 1'b0;
        bus.start_i = 1'b0;
        @(posedge clk); #1;

        // Unsigned quotient and remainder
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);

        // Flush at the tenth CALC cycle
        bus.start_i    = 1'b1;
        bus.op_i       = OP_DIVU;
        bus.dividend_i = 32'hFFFF_FFFF;
        bus.divisor_i  = 32'd3;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        bus.flush_i = 1'b1;
        #1;
        check("flush/busy_before", 32'(bus.busy_o), 32'd1);
        check("flush/hold_before", 32'(bus.hold_o), 32'd1);
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        #1;
        check("flush/busy_after", 32'(bus.busy_o), 32'd0);
        check("flush/hold_after", 32'(bus.hold_o), 32'd0);
        check("flush/done_after", 32'(bus.done_o), 32'd0);
        check("flush/result_held", bus.result_o, 32'd2);
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done_o === 1'b1) dones++;
        end
        check("flush/no_done", 32'(dones), 32'd0);
        $display("[TB] flush at CALC cycle 10: dones=%0d result=%h", dones, bus.result_o);
        run_op("divu_after_flush", OP_DIVU, 32'd1000, 32'd10, 32'd100, 33);

        // Signed operations
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);

        // Divide by zero bypass
        run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5, 1);

        // Signed overflow bypass
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

        // Start pulses during CALC must be ignored
        bus.start_i    = 1'b1;
        bus.op_i       = OP_DIVU;
        bus.dividend_i = 32'hFFFF_FFFF;
        bus.divisor_i  = 32'd3;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        cycles = 1;
        while (bus.done_o !== 1'b1 && cycles < 100) begin
            bus.start_i    = (cycles >= 5 && cycles < 8);
            bus.op_i       = OP_REM;
            bus.dividend_i = 32'd10;
            bus.divisor_i  = 32'd0;
            @(posedge clk); #1;
            cycles++;
            if (cycles == 6) check("calc_start/busy", 32'(bus.busy_o), 32'd1);
        end
        bus.start_i = 1'b0;
        check("calc_start/latency", 32'(cycles), 32'd33);
        check("calc_start/result", bus.result_o, 32'h5555_5555);
        $display("[TB] start during CALC: result=%h cycles=%0d", bus.result_o, cycles);
        @(posedge clk); #1;

        // Reset in the middle of CALC together with start
        bus.start_i    = 1'b1;
        bus.op_i       = OP_DIVU;
        bus.dividend_i = 32'd100;
        bus.divisor_i  = 32'd7;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("rst_calc/busy_before", 32'(bus.busy_o), 32'd1);
        rst         = 1'b1;
        bus.start_i = 1'b1;
        #1;
        check("rst_calc/hold_comb", 32'(bus.hold_o), 32'd0);
        @(posedge clk); #1;
        check("rst_calc/busy", 32'(bus.busy_o), 32'd0);
        check("rst_calc/done", 32'(bus.done_o), 32'd0);
        check("rst_calc/result", bus.result_o, 32'd0);
        check("rst_calc/hold", 32'(bus.hold_o), 32'd0);
        rst         = 1'b0;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        check("rst_calc/idle_busy", 32'(bus.busy_o), 32'd0);
        $display("[TB] reset mid-CALC: busy=%0d done=%0d result=%h", bus.busy_o, bus.done_o, bus.result_o);
        run_op("divu_after_rst", OP_DIVU, 32'd1000, 32'd10, 32'd100, 33);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mdu_div.md
MDU_DIV -- requirements
Module: mdu_div

Interface
REQ-001 SHALL have parameter XLEN, default 32, the operand and result width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start_i, input, 1, request a divide; accepted only in IDLE.
REQ-005 SHALL have port op_i, input, 2, selects the operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port dividend_i, input, XLEN, rs1 operand; sampled on the accept cycle only.
REQ-007 SHALL have port divisor_i, input, XLEN, rs2 operand; sampled on the accept cycle only.
REQ-008 SHALL have port flush_i, input, 1, aborts any operation in progress.
REQ-009 SHALL have port hold_o, output, 1, stall request driven to the pipeline-register hold inputs.
REQ-010 SHALL have port busy_o, output, 1, high while in CALC.
REQ-011 SHALL have port done_o, output, 1, one-cycle pulse marking result_o valid.
REQ-012 SHALL have port result_o, output, XLEN, quotient or remainder as selected by op_i.

Function
REQ-013 SHALL implement states IDLE, CALC and DONE.
REQ-014 SHALL accept a request when start_i=1 in IDLE with flush_i=0: latch op_i, the operand absolute values for signed ops (raw values for unsigned ops) and the result sign; then go to CALC with count=0.
REQ-015 SHALL in CALC perform one restoring shift-subtract step per cycle, MSB first, for exactly XLEN cycles, then go to DONE.
REQ-016 SHALL, when divisor_i=0 at accept, skip CALC and go directly to DONE: quotient all ones, remainder = dividend_i.
REQ-017 SHALL, for DIV/REM with dividend = -2^(XLEN-1) and divisor = -1, produce quotient -2^(XLEN-1) and remainder 0 (this case may also bypass CALC).
REQ-018 SHALL negate the quotient when the operand signs differ (signed ops only), and give the remainder the dividend's sign.
REQ-019 SHALL in DONE assert done_o for one cycle with result_o valid, then return to IDLE.
REQ-020 SHALL have latency XLEN+1 cycles from accept to done_o (32 cycles for XLEN=32 gives done_o at cycle 33), and 1 cycle for the bypass cases.
REQ-021 SHALL drive hold_o combinationally: hold_o = (IDLE and start_i and not flush_i) or CALC; hold_o SHALL be 0 in DONE so the pipeline captures result_o.
REQ-022 SHALL ignore start_i outside IDLE.
REQ-023 SHALL, on flush_i=1 in any state, go to IDLE next cycle with done_o=0; flush_i takes priority over start_i.
REQ-024 SHALL hold result_o at its last value outside DONE.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, enter IDLE, clear count, and set busy_o, done_o and result_o to 0, regardless of state; reset overrides flush_i and start_i.
REQ-026 SHALL keep hold_o at 0 during reset.

Structure
REQ-027 SHALL take the op_i encodings and the zero-word constant from the shared buceros header; state encodings SHALL be local.
REQ-028 SHALL be a single module with no sub-modules; quotient, remainder and counter registers are inline.

Verification
REQ-029 SHALL cover DIVU 100/7: done_o at cycle 33 after accept with result 14; REMU 100/7 gives 2.
REQ-030 SHALL cover signed ops: DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; DIV 7/-2 gives 0xFFFFFFFD.
REQ-031 SHALL cover divide by zero: DIVU 5/0 gives 0xFFFFFFFF and REM 5/0 gives 5, with done_o one cycle after accept.
REQ-032 SHALL cover overflow: DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM of the same operands gives 0.
REQ-033 SHALL cover flush at CALC cycle 10: IDLE next cycle, no done_o, and hold_o deasserted; a new start is then accepted normally.
REQ-034 SHALL cover rst=1 mid-CALC together with start_i=1: all outputs 0 and state IDLE; start_i during CALC has no effect.
